// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared mode type, default sizes and parameter-legality helpers for sync_fifo_param
package sync_fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AF_LEVEL = DEF_DEPTH - 2;
    localparam int DEF_AE_LEVEL = 2;

    function automatic bit depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction

    function automatic bit levels_ok(input int af, input int ae, input int depth);
        return af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1 && ae < af;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO storage array, one synchronous write port and one asynchronous read port
// Ports: clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata combinational read port. No reset.
module sync_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level thresholds, error pulses and STD/FWFT read modes
// Ports: clk, reset (async, active-low); w_en/data_in write side; r_en/data_out read side;
//        counter occupancy 0..DEPTH; full/empty/almost_full/almost_empty decoded from counter;
//        overflow/underflow one-cycle pulses for rejected writes/reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_W   = DEF_DATA_W,
    parameter int         DEPTH    = DEF_DEPTH,
    parameter int         AF_LEVEL = DEPTH - 2,
    parameter int         AE_LEVEL = DEF_AE_LEVEL,
    parameter fifo_mode_e MODE     = FIFO_STD,
    localparam int        AW       = $clog2(DEPTH),
    localparam int        CW       = $clog2(DEPTH + 1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [CW-1:0]     counter,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!levels_ok(AF_LEVEL, AE_LEVEL, DEPTH)) begin : g_bad_levels
        $error("sync_fifo_param: need 1<=AF_LEVEL<=DEPTH, 0<=AE_LEVEL<DEPTH, AE_LEVEL<AF_LEVEL");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be >= 1");
    end

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_unf;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rdata;

    assign full         = r_count == CW'(DEPTH);
    assign empty        = r_count == '0;
    assign almost_full  = r_count >= CW'(AF_LEVEL);
    assign almost_empty = r_count <= CW'(AE_LEVEL);
    assign counter      = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign w_wr_ok = w_en && (!full || r_en);
    assign w_rd_ok = r_en && !empty;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_ok);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd_ok);
            r_count  <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
            r_ovf    <= w_en && !w_wr_ok;
            r_unf    <= r_en && !w_rd_ok;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok && reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign data_out = empty ? '0 : w_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] r_dout;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) r_dout <= '0;
            else if (w_rd_ok) r_dout <= w_rdata;
        end
        assign data_out = r_dout;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: drives STD and FWFT instances with shared stimulus, checks both against a queue model
module tb_sync_fifo_param;
    import sync_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] s_dout, f_dout;
    logic [3:0] s_cnt, f_cnt;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int n_chk = 0;
    int n_bad = 0;
    int q[$];
    int exp_std = 0;
    int exp_ovf = 0;
    int exp_unf = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_STD)) u_std (
        .clk(clk), .reset(reset), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(s_dout), .counter(s_cnt), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .reset(reset), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(f_dout), .counter(f_cnt), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string t);
        int n = q.size();
        check({t, ".cnt"},   int'(s_cnt),   n);
        check({t, ".full"},  int'(s_full),  int'(n == DEPTH));
        check({t, ".empty"}, int'(s_empty), int'(n == 0));
        check({t, ".af"},    int'(s_af),    int'(n >= AFL));
        check({t, ".ae"},    int'(s_ae),    int'(n <= AEL));
        check({t, ".ovf"},   int'(s_ovf),   exp_ovf);
        check({t, ".unf"},   int'(s_unf),   exp_unf);
        check({t, ".sdout"}, int'(s_dout),  exp_std);
        check({t, ".fcnt"},  int'(f_cnt),   n);
        check({t, ".fovf"},  int'(f_ovf),   exp_ovf);
        check({t, ".funf"},  int'(f_unf),   exp_unf);
        check({t, ".fdout"}, int'(f_dout),  n == 0 ? 0 : q[0]);
    endtask

    // One cycle of traffic: drive on the falling edge, update the model at the rising edge, compare just after.
    task automatic step(input string t, input bit w, input bit r, input int d);
        bit wr_ok, rd_ok;
        @(negedge clk);
        w_en = w;
        r_en = r;
        data_in = d[7:0];
        @(posedge clk);
        wr_ok = w && (q.size() < DEPTH || r);
        rd_ok = r && q.size() > 0;
        if (rd_ok) exp_std = q.pop_front();
        if (wr_ok) q.push_back(d & 8'hff);
        exp_ovf = int'(w && !wr_ok);
        exp_unf = int'(r && !rd_ok);
        #1;
        compare_all(t);
    endtask

    // Reset is applied between edges to show it acts without a clock.
    task automatic do_reset(input string t);
        @(negedge clk);
        reset = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        #1;
        q.delete();
        exp_std = 0;
        exp_ovf = 0;
        exp_unf = 0;
        compare_all({t, ".async"});
        @(posedge clk);
        #1;
        compare_all({t, ".held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= 8; i++) step("fill", 1, 0, i);
        step("ovf", 1, 0, 9);
        step("ovf_clr", 0, 0, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 1, 0);
        step("unf", 0, 1, 0);
        step("unf_clr", 0, 0, 0);

        for (int i = 0; i < 8; i++) step("refill", 1, 0, 8'h10 + i);
        step("full_rw", 1, 1, 8'hAA);
        for (int i = 0; i < 8; i++) step("drain_aa", 0, 1, 0);
        check("aa_out", int'(s_dout), 8'hAA);

        step("empty_rw", 1, 1, 8'h55);
        step("read_55", 0, 1, 0);
        check("out_55", int'(s_dout), 8'h55);

        step("fwft_wr", 1, 0, 8'h3C);
        check("fwft_3c", int'(f_dout), 8'h3C);
        step("fwft_rd", 0, 1, 0);
        check("fwft_zero", int'(f_dout), 0);

        for (int i = 0; i < 5; i++) step("burst", 1, 0, 8'hC0 + i);
        do_reset("mid_rst");
        step("post_rst", 1, 0, 8'h77);

        for (int i = 0; i < 600; i++) begin
            int ph = (i / 60) % 3;
            int wp = ph == 0 ? 80 : ph == 1 ? 20 : 50;
            int rp = ph == 0 ? 20 : ph == 1 ? 80 : 50;
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            else step("rnd", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom_range(0, 255));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
